// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the shared
// datapath (slave): IR/ALU/memory status in, datapath steering strobes out.
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic [1:0]  fault;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, fault, cycle_count, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, fault, cycle_count, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset sequencer with memory timeout and illegal-opcode halt.
// Define MULTICYCLE_PERF_EN to build the cycle/instruction performance counters.
module multicycle_control #(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC     = 4'd6,
        RTYPEWB  = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        HALT     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wait_reg, wait_next;
    logic [1:0] fault_reg, fault_next;

    logic       pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
    logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;
    logic       mem_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            wait_reg  <= 8'd0;
            fault_reg <= FAULT_NONE;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        fault_next   = fault_reg;
        mem_wait     = 1'b0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_dst_c    = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        pc_source_c  = 2'b00;

        case (state_reg)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_next = EXEC;
                    OP_LW, OP_SW: state_next = MEMADDR;
                    OP_BEQ,
                    OP_BNE:       state_next = BRANCH;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next = HALT;
                        fault_next = FAULT_ILLEGAL;
                    end
                endcase
            end
            MEMADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_next  = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_next   = FETCH;
            end
            MEMWRITE: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (bus.mem_ready) begin
                    state_next = FETCH;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_next  = RTYPEWB;
            end
            RTYPEWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_next  = FETCH;
            end
            BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b01;
                pc_source_c = 2'b01;
                pc_write_c  = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                              ((bus.opcode == OP_BNE) && !bus.zero);
                state_next  = FETCH;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                state_next  = FETCH;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // A stall that has already lasted TIMEOUT cycles aborts; a ready on the
        // same cycle never reaches this branch because mem_wait stays low.
        if (mem_wait && (wait_reg == TIMEOUT_L)) begin
            state_next = HALT;
            fault_next = FAULT_TIMEOUT;
        end
    end

    assign wait_next = (mem_wait && (state_next == state_reg)) ? wait_reg + 8'd1 : 8'd0;

    // Strobes are forced low while reset is held so an aborted store never writes.
    assign bus.pc_write   = pc_write_c   & ~rst;
    assign bus.ir_write   = ir_write_c   & ~rst;
    assign bus.iord       = iord_c       & ~rst;
    assign bus.mem_read   = mem_read_c   & ~rst;
    assign bus.mem_write  = mem_write_c  & ~rst;
    assign bus.mem_to_reg = mem_to_reg_c & ~rst;
    assign bus.reg_dst    = reg_dst_c    & ~rst;
    assign bus.reg_write  = reg_write_c  & ~rst;
    assign bus.alu_src_a  = alu_src_a_c  & ~rst;
    assign bus.alu_src_b  = alu_src_b_c  & {2{~rst}};
    assign bus.alu_op     = alu_op_c     & {2{~rst}};
    assign bus.pc_source  = pc_source_c  & {2{~rst}};
    assign bus.state      = state_reg;
    assign bus.fault      = fault_reg;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_reg, instr_reg;
    logic        instr_done;

    assign instr_done = (state_next == FETCH) &&
                        ((state_reg == MEMWB)   || (state_reg == MEMWRITE) ||
                         (state_reg == RTYPEWB) || (state_reg == BRANCH)   ||
                         (state_reg == JUMP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_reg <= 32'd0;
            instr_reg <= 32'd0;
        end else begin
            if (state_reg != HALT) begin
                cycle_reg <= cycle_reg + 32'd1;
            end
            if (instr_done) begin
                instr_reg <= instr_reg + 32'd1;
            end
        end
    end

    assign bus.cycle_count = cycle_reg;
    assign bus.instr_count = instr_reg;
`else
    assign bus.cycle_count = 32'd0;
    assign bus.instr_count = 32'd0;
`endif
endmodule
